// File: rtl/freelist_nway.sv
// freelist_nway: multi-lane physical-register free list (circular buffer) with rd-pointer checkpoints.
// Define FREELIST_STATS_EN to enable the stall_cycles / min_free statistics outputs.
module freelist_nway_chk #(
    parameter int DEPTH = 32,
    parameter int QW    = 6
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [QW-1:0] free_count,
    input  logic [31:0]   n_free,
    input  logic [31:0]   n_gnt
);
    // Retire frees must never push occupancy past the buffer capacity.
    property p_no_overflow;
        @(posedge clock) disable iff (reset)
            (32'(free_count) + n_free) <= (32'(DEPTH) + n_gnt);
    endproperty
    a_no_overflow: assert property (p_no_overflow);
endmodule

module freelist_nway #(
    parameter int  WIDTH    = 2,
    parameter int  NUM_PR   = 64,
    parameter int  NUM_AR   = 32,
    parameter int  NUM_CKPT = 4,
    localparam int PW       = $clog2(NUM_PR),
    localparam int DEPTH    = NUM_PR - NUM_AR,
    localparam int QW       = $clog2(DEPTH) + 1,
    localparam int CW       = (NUM_CKPT > 1) ? $clog2(NUM_CKPT) : 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [WIDTH-1:0]    alloc_req,
    output logic [WIDTH-1:0]    alloc_gnt,
    output logic [WIDTH*PW-1:0] alloc_preg,
    output logic                alloc_stall,
    input  logic [WIDTH-1:0]    free_en,
    input  logic [WIDTH*PW-1:0] free_preg,
    input  logic                ckpt_en,
    input  logic [CW-1:0]       ckpt_id,
    input  logic                rollback_en,
    input  logic [CW-1:0]       rollback_id,
    output logic [QW-1:0]       free_count,
    output logic [31:0]         stall_cycles,
    output logic [QW-1:0]       min_free
);
    localparam int IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PTR_MOD = 2 * DEPTH;

    function automatic int unsigned popcnt_below(input logic [WIDTH-1:0] v, input int k);
        int unsigned c;
        c = 32'd0;
        for (int i = 0; i < k; i++) begin
            c = c + 32'(v[i]);
        end
        return c;
    endfunction

    function automatic logic [QW-1:0] ptr_add(input logic [QW-1:0] p, input int unsigned n);
        int unsigned s;
        s = 32'(p) + n;
        if (s >= 32'(PTR_MOD)) s = s - 32'(PTR_MOD);
        else                   s = s;
        return QW'(s);
    endfunction

    function automatic logic [IW-1:0] ptr_idx(input logic [QW-1:0] p);
        int unsigned s;
        s = 32'(p);
        if (s >= 32'(DEPTH)) s = s - 32'(DEPTH);
        else                 s = s;
        return IW'(s);
    endfunction

    function automatic logic [QW-1:0] ptr_dist(input logic [QW-1:0] w, input logic [QW-1:0] r);
        int unsigned d;
        if (w >= r) d = 32'(w) - 32'(r);
        else        d = 32'(w) + 32'(PTR_MOD) - 32'(r);
        return QW'(d);
    endfunction

    logic [PW-1:0]       r_entry [DEPTH];
    logic [QW-1:0]       r_ckpt  [NUM_CKPT];
    logic [QW-1:0]       r_rd_ptr;
    logic [QW-1:0]       r_wr_ptr;

    logic [WIDTH-1:0]    w_free_valid;
    logic [IW-1:0]       w_rd_idx [WIDTH];
    logic [IW-1:0]       w_wr_idx [WIDTH];
    int unsigned         w_n_req;
    int unsigned         w_n_free;
    logic [31:0]         w_n_gnt;
    logic                w_grant;
    logic [QW-1:0]       w_free_count;
    logic [QW-1:0]       w_rd_next;
    logic [QW-1:0]       w_wr_next;
    logic [WIDTH*PW-1:0] w_alloc_preg;

    // Grant decision, per-lane read/write slots and next pointers.
    always_comb begin
        w_alloc_preg = '0;
        w_n_req      = popcnt_below(alloc_req, WIDTH);
        for (int k = 0; k < WIDTH; k++) begin
            w_free_valid[k] = free_en[k] && (free_preg[k*PW +: PW] != '0);
        end
        w_n_free     = popcnt_below(w_free_valid, WIDTH);
        w_free_count = ptr_dist(r_wr_ptr, r_rd_ptr);
        w_grant      = !reset && !rollback_en && (w_n_req <= 32'(w_free_count));
        for (int k = 0; k < WIDTH; k++) begin
            w_rd_idx[k] = ptr_idx(ptr_add(r_rd_ptr, popcnt_below(alloc_req, k)));
            w_wr_idx[k] = ptr_idx(ptr_add(r_wr_ptr, popcnt_below(w_free_valid, k)));
            if (w_grant && alloc_req[k]) w_alloc_preg[k*PW +: PW] = r_entry[w_rd_idx[k]];
            else                         w_alloc_preg[k*PW +: PW] = '0;
        end
        if (w_grant) begin
            w_rd_next = ptr_add(r_rd_ptr, w_n_req);
            w_n_gnt   = w_n_req;
        end else begin
            w_rd_next = r_rd_ptr;
            w_n_gnt   = 32'd0;
        end
        w_wr_next = ptr_add(r_wr_ptr, w_n_free);
    end

    // Buffer, pointer and checkpoint state; rollback overrides both grant and checkpoint.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= QW'(DEPTH);
            for (int i = 0; i < DEPTH; i++) begin
                r_entry[i] <= PW'(NUM_AR + i);
            end
            for (int i = 0; i < NUM_CKPT; i++) begin
                r_ckpt[i] <= '0;
            end
        end else begin
            for (int k = 0; k < WIDTH; k++) begin
                if (w_free_valid[k]) r_entry[w_wr_idx[k]] <= free_preg[k*PW +: PW];
            end
            r_wr_ptr <= w_wr_next;
            if (rollback_en) begin
                r_rd_ptr <= r_ckpt[rollback_id];
            end else begin
                r_rd_ptr <= w_rd_next;
                if (ckpt_en) r_ckpt[ckpt_id] <= w_rd_next;
            end
        end
    end

    assign alloc_gnt   = w_grant ? alloc_req : '0;
    assign alloc_preg  = w_alloc_preg;
    assign alloc_stall = !reset && (|alloc_req) && !w_grant;
    assign free_count  = w_free_count;

`ifdef FREELIST_STATS_EN
    logic [31:0]   r_stall_cycles;
    logic [QW-1:0] r_min_free;

    // Saturating stall counter and low-water mark of the free count.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_stall_cycles <= 32'd0;
            r_min_free     <= QW'(DEPTH);
        end else begin
            if (alloc_stall && (r_stall_cycles != 32'hFFFF_FFFF)) r_stall_cycles <= r_stall_cycles + 32'd1;
            else                                                  r_stall_cycles <= r_stall_cycles;
            if (w_free_count < r_min_free) r_min_free <= w_free_count;
            else                           r_min_free <= r_min_free;
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign min_free     = r_min_free;
`else
    assign stall_cycles = 32'd0;
    assign min_free     = '0;
`endif

    freelist_nway_chk #(.DEPTH(DEPTH), .QW(QW)) u_chk (
        .clock      (clock),
        .reset      (reset),
        .free_count (w_free_count),
        .n_free     (w_n_free),
        .n_gnt      (w_n_gnt)
    );
endmodule

// File: doc/freelist_nway.md
FREELIST_NWAY -- requirements
Module: freelist_nway

Interface
REQ-001 Parameter WIDTH, default 2, SHALL set the number of allocate and free lanes per cycle.
REQ-002 Parameter NUM_PR, default 64, SHALL set the physical register count; PW = $clog2(NUM_PR).
REQ-003 Parameter NUM_AR, default 32, SHALL set the architectural register count; DEPTH = NUM_PR - NUM_AR free-list entries.
REQ-004 Parameter NUM_CKPT, default 4, SHALL set the checkpoint slot count; CW = $clog2(NUM_CKPT).
REQ-005 clock  in  1  SHALL be the clock; all state updates on its rising edge.
REQ-006 reset  in  1  SHALL be a synchronous, active-high reset.
REQ-007 alloc_req  in  WIDTH  SHALL carry per-lane allocation requests; the caller has already filtered out destination x0.
REQ-008 alloc_gnt  out  WIDTH  SHALL carry per-lane grants.
REQ-009 alloc_preg  out  WIDTH*PW  SHALL carry the per-lane allocated preg; 0 on non-granted lanes.
REQ-010 alloc_stall  out  1  SHALL be high when any request is pending and none is granted.
REQ-011 free_en  in  WIDTH  SHALL carry per-lane retire frees.
REQ-012 free_preg  in  WIDTH*PW  SHALL carry the per-lane Told preg to free.
REQ-013 ckpt_en / ckpt_id  in  1 / CW  SHALL request a checkpoint into slot ckpt_id.
REQ-014 rollback_en / rollback_id  in  1 / CW  SHALL request a restore from slot rollback_id.
REQ-015 free_count  out  $clog2(DEPTH)+1  SHALL carry the registered number of free entries.

Function
REQ-016 Storage SHALL be a circular buffer of DEPTH PW-bit entries with rd_ptr and wr_ptr, each $clog2(DEPTH)+1 bits including a wrap bit; free_count = wr_ptr - rd_ptr, range 0..DEPTH, so full and empty are unambiguous.
REQ-017 With n_req = popcount(alloc_req), lane k SHALL receive entry[rd_ptr + popcount(alloc_req[k-1:0])] (mod DEPTH), combinationally in the same cycle.
REQ-018 Grants SHALL be all-or-nothing: alloc_gnt = alloc_req if n_req <= free_count, else 0; rd_ptr SHALL advance by n_req only when granted.
REQ-019 Each lane with free_en set and free_preg != 0 SHALL be written, compacted in lane order, at wr_ptr; wr_ptr SHALL advance by the valid-free count; preg 0 SHALL be ignored.
REQ-020 Frees SHALL become allocatable in the cycle after they are written, with one-cycle latency and no same-cycle bypass.
REQ-021 Simultaneous allocate and free SHALL both take effect; next free_count = free_count - granted + freed.
REQ-022 Pointer arithmetic SHALL wrap modulo 2*DEPTH, and entry indexing modulo DEPTH, including a group that straddles index DEPTH-1 -> 0.
REQ-023 ckpt_en SHALL store the post-grant rd_ptr of the same cycle into slot ckpt_id.
REQ-024 rollback_en SHALL load rd_ptr from slot rollback_id and force alloc_gnt = 0 that cycle; frees in that cycle SHALL still apply; wr_ptr SHALL be unaffected.
REQ-025 rollback_en SHALL take priority over ckpt_en in the same cycle, and the checkpoint SHALL be dropped.
REQ-026 Frees that would make free_count exceed DEPTH are illegal; the design SHALL carry a simulation assertion for this case.

Reset
REQ-027 Reset SHALL set rd_ptr = 0, wr_ptr = DEPTH (wrap bit set), entry[i] = NUM_AR + i, all checkpoint slots = 0, free_count = DEPTH.
REQ-028 While reset is high, alloc_gnt SHALL be 0, alloc_preg SHALL be 0 and alloc_stall SHALL be 0, overriding any in-flight request, free or rollback.

Configuration
REQ-029 Macro FREELIST_STATS_EN, when defined, SHALL add outputs stall_cycles (32-bit, saturating, incremented each cycle alloc_stall = 1) and min_free (lowest free_count since reset); both SHALL reset to 0 and DEPTH respectively.
REQ-030 Without FREELIST_STATS_EN, stall_cycles and min_free SHALL be tied to 0 and no counter logic SHALL exist.

Verification (WIDTH=2, NUM_PR=64, NUM_AR=32, NUM_CKPT=4)
REQ-031 Post-reset alloc_req=11 -> alloc_gnt=11, alloc_preg={33,32}; next free_count=30.
REQ-032 Post-reset alloc_req=10 -> lane1 gets preg 32, lane0 gets 0; next free_count=31.
REQ-033 Sixteen cycles of alloc_req=11 -> free_count=0; then alloc_req=11 -> gnt=00, stall=1; free 40,41 -> grant of {41,40} in the following cycle, not the same one.
REQ-034 free_count=1, alloc_req=11 -> gnt=00, stall=1, free_count unchanged.
REQ-035 Post-reset alloc 11 plus ckpt_en id=2, then two more 11 allocations, then rollback id=2 -> next alloc 11 returns {35,34}, free_count=30.
REQ-036 Wrap test: fill, drain and refill so a two-lane free straddles entry 31 -> 0 -> subsequent allocations return the freed pregs in free order.
